// File: rtl/fpu_mul_pkg.sv
// Shared constants and stage bundles for the FP32 multiply scheduler.
package fpu_mul_pkg;
   localparam int FP32_W = 32;
   localparam int SIGN_W = 1;
   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int BIAS   = 127;

   typedef struct packed {
      logic              valid;
      logic [FP32_W-1:0] a;
      logic [FP32_W-1:0] b;
   } s1_t;

   typedef struct packed {
      logic              valid;
      logic [FP32_W-1:0] res;
   } s2_t;
endpackage

// File: rtl/fpu_mul_scheduler_rr_arbiter.sv
// Round-robin grant: first valid requester after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);
   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
   end
endmodule

// File: rtl/multiplication.sv
// Combinational FP32 multiply core; truncating, no special-case handling.
module multiplication
   import fpu_mul_pkg::*;
(
   input  logic [FP32_W-1:0] a,
   input  logic [FP32_W-1:0] b,
   output logic [FP32_W-1:0] res
);
   logic [2*MAN_W+1:0] prod;
   logic [EXP_W+1:0]   exp_sum;
   logic [MAN_W-1:0]   man;
   logic               sign;

   always_comb begin
      prod = (2*MAN_W+2)'({1'b1, a[MAN_W-1:0]})
           * (2*MAN_W+2)'({1'b1, b[MAN_W-1:0]});
      // Product of two 1.x mantissas lies in [1,4); top bit selects shift.
      exp_sum = (EXP_W+2)'(a[FP32_W-2:MAN_W])
              + (EXP_W+2)'(b[FP32_W-2:MAN_W])
              - (EXP_W+2)'(BIAS)
              + (EXP_W+2)'(prod[2*MAN_W+1]);
      man = prod[2*MAN_W+1] ? prod[2*MAN_W:MAN_W+1]
                            : prod[2*MAN_W-1:MAN_W];
      sign = a[FP32_W-1] ^ b[FP32_W-1];
      res = {sign, exp_sum[EXP_W-1:0], man};
   end
endmodule

// File: rtl/fpu_mul_scheduler.sv
// Two-stage scheduler sharing one FP32 multiply core among requesters.
module fpu_mul_scheduler
   import fpu_mul_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [FP32_W*NUM_REQ-1:0] req_a,
   input  logic [FP32_W*NUM_REQ-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [FP32_W-1:0]         rsp_res,
   output logic                      busy,
   output logic [CNT_W-1:0]          op_count
);
   s1_t               s1_q, s1_d;
   s2_t               s2_q, s2_d;
   logic [ID_W-1:0]   s1_id_q, s1_id_d;
   logic [ID_W-1:0]   s2_id_q, s2_id_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic              s1_load, s2_load, accept;
   logic [FP32_W-1:0] mul_res;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req   (req_valid),
      .ptr   (rr_q),
      .grant (gnt),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   multiplication u_mul (
      .a   (s1_q.a),
      .b   (s1_q.b),
      .res (mul_res)
   );

   always_comb begin
      s2_load = s1_q.valid & (~s2_q.valid | rsp_ready);
      s1_load = ~s1_q.valid | s2_load;
      // Masked by rst_n so nothing looks accepted while held in reset.
      accept    = s1_load & gnt_any & rst_n;
      req_ready = accept ? gnt : '0;

      s1_d    = s1_q;
      s1_id_d = s1_id_q;
      if (s1_load) begin
         s1_d.valid = accept;
         if (accept) begin
            s1_d.a  = req_a[int'(gnt_idx)*FP32_W +: FP32_W];
            s1_d.b  = req_b[int'(gnt_idx)*FP32_W +: FP32_W];
            s1_id_d = gnt_idx;
         end
      end

      s2_d    = s2_q;
      s2_id_d = s2_id_q;
      if (s2_load) begin
         s2_d.valid = 1'b1;
         s2_d.res   = mul_res;
         s2_id_d    = s1_id_q;
      end else if (rsp_ready) begin
         s2_d.valid = 1'b0;
      end

      rr_d  = accept ? gnt_idx : rr_q;
      cnt_d = (s2_q.valid & rsp_ready) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s1_id_q <= '0;
         s2_id_q <= '0;
         rr_q    <= ID_W'(NUM_REQ-1);
         cnt_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s1_id_q <= s1_id_d;
         s2_id_q <= s2_id_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp_valid = s2_q.valid;
   assign rsp_res   = s2_q.res;
   assign rsp_id    = s2_id_q;
   assign busy      = s1_q.valid | s2_q.valid;
   assign op_count  = cnt_q;
endmodule
